// File: rtl/raxi_fifo.sv
// rtl/raxi_fifo.sv - rAXI valid/ready FIFO, first-word-fall-through, optional drop-on-full
// Single clock domain; storage is not reset, only pointers, count and status.
module raxi_fifo #(
   parameter int DW           = 10,
   parameter int DEPTH        = 8,
   parameter int AF_LEVEL     = DEPTH - 1,
   parameter int AE_LEVEL     = 1,
   parameter int DROP_ON_FULL = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [DW-1:0]                s_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [DW-1:0]                m_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic                         drop
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_L = CW'(DEPTH);
   localparam logic [CW-1:0] AF_L   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_L   = CW'(AE_LEVEL);
   localparam logic [PW-1:0] LAST_P = PW'(DEPTH - 1);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          empty;
   logic          wr_en;
   logic          rd_en;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_P) ? '0 : p + PW'(1);
   endfunction

   assign full         = (count == FULL_L);
   assign empty        = (count == '0);
   assign s_ready      = (DROP_ON_FULL != 0) ? 1'b1 : (!full && !rst);
   assign m_valid      = !empty;
   assign m_data       = m_valid ? mem[rd_ptr] : '0;
   assign almost_full  = (count >= AF_L);
   assign almost_empty = (count <= AE_L);

   // In drop mode a beat arriving while full is lost even if a read frees a slot.
   assign wr_en = s_valid && s_ready && !full && !rst;
   assign rd_en = m_valid && m_ready;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         drop   <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (rd_en) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         drop <= (DROP_ON_FULL != 0) && s_valid && full;
      end
   end

endmodule

// File: tb/tb_raxi_fifo.sv
// tb/tb_raxi_fifo.sv - randomized queue-model bench for raxi_fifo, blocking and drop instances
module tb_raxi_fifo;

   localparam int DW = 10;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          bv, bm, dv, dm;
   logic [DW-1:0] bd, dd;
   logic          b_s_ready, b_m_valid, b_af, b_ae, b_drop;
   logic          d_s_ready, d_m_valid, d_af, d_ae, d_drop;
   logic [DW-1:0] b_m_data, d_m_data;
   logic [2:0]    b_count, d_count;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] qb[$];
   logic [DW-1:0] qd[$];
   logic          drop_exp;
   logic          last_wr_b;
   logic          last_wr_d;

   always #5 clk = ~clk;

   raxi_fifo #(.DW(DW), .DEPTH(DEPTH), .AF_LEVEL(3), .AE_LEVEL(1), .DROP_ON_FULL(0)) u_blk (
      .clk(clk), .rst(rst),
      .s_valid(bv), .s_ready(b_s_ready), .s_data(bd),
      .m_valid(b_m_valid), .m_ready(bm), .m_data(b_m_data),
      .count(b_count), .almost_full(b_af), .almost_empty(b_ae), .drop(b_drop)
   );

   raxi_fifo #(.DW(DW), .DEPTH(DEPTH), .AF_LEVEL(3), .AE_LEVEL(1), .DROP_ON_FULL(1)) u_drp (
      .clk(clk), .rst(rst),
      .s_valid(dv), .s_ready(d_s_ready), .s_data(dd),
      .m_valid(d_m_valid), .m_ready(dm), .m_data(d_m_data),
      .count(d_count), .almost_full(d_af), .almost_empty(d_ae), .drop(d_drop)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   // Compare all outputs against the queue model, then advance one clock and update the model.
   task automatic cycle();
      logic [DW-1:0] hb, hd;
      bit rdb, wrb, rdd, wrd, fulld;
      #1;
      hb = (qb.size() > 0) ? qb[0] : '0;
      hd = (qd.size() > 0) ? qd[0] : '0;
      check("b_s_ready", 32'(b_s_ready), 32'(!rst && qb.size() < DEPTH));
      check("b_m_valid", 32'(b_m_valid), 32'(qb.size() > 0));
      check("b_m_data",  32'(b_m_data),  32'(hb));
      check("b_count",   32'(b_count),   32'(qb.size()));
      check("b_af",      32'(b_af),      32'(qb.size() >= 3));
      check("b_ae",      32'(b_ae),      32'(qb.size() <= 1));
      check("b_drop",    32'(b_drop),    32'(0));
      check("d_s_ready", 32'(d_s_ready), 32'(1));
      check("d_m_valid", 32'(d_m_valid), 32'(qd.size() > 0));
      check("d_m_data",  32'(d_m_data),  32'(hd));
      check("d_count",   32'(d_count),   32'(qd.size()));
      check("d_af",      32'(d_af),      32'(qd.size() >= 3));
      check("d_ae",      32'(d_ae),      32'(qd.size() <= 1));
      check("d_drop",    32'(d_drop),    32'(drop_exp));
      @(posedge clk);
      last_wr_b = 1'b0;
      last_wr_d = 1'b0;
      if (rst) begin
         qb.delete();
         qd.delete();
         drop_exp = 1'b0;
      end else begin
         rdb = (qb.size() > 0) && bm;
         wrb = bv && (qb.size() < DEPTH);
         if (rdb) void'(qb.pop_front());
         if (wrb) qb.push_back(bd);
         last_wr_b = wrb;
         fulld = (qd.size() == DEPTH);
         rdd = (qd.size() > 0) && dm;
         wrd = dv && !fulld;
         if (rdd) void'(qd.pop_front());
         if (wrd) qd.push_back(dd);
         last_wr_d = wrd;
         drop_exp = dv && fulld;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      bv = 0; bm = 0; dv = 0; dm = 0; bd = '0; dd = '0;
   endtask

   task automatic drain();
      bv = 0; dv = 0; bm = 1; dm = 1;
      for (int i = 0; i < 2 * DEPTH + 2; i++) cycle();
      check("drained_b", 32'(b_count), 32'(0));
      check("drained_d", 32'(d_count), 32'(0));
      idle();
   endtask

   initial begin
      int pushed;
      int budget;
      drop_exp = 1'b0;
      idle();
      rst = 1;
      @(negedge clk);
      cycle();
      cycle();
      rst = 0;
      cycle();

      // Fill blocking FIFO, then hold a 5th beat against backpressure.
      for (int i = 1; i <= 4; i++) begin
         bv = 1; bd = DW'(i);
         cycle();
      end
      bd = 10'h005;
      for (int i = 0; i < 3; i++) cycle();
      check("full_no_accept", 32'(b_count), 32'(4));

      // Drain in order; the held beat goes in once a slot frees.
      bm = 1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (last_wr_b) bv = 0;
      end
      bv = 0;
      drain();

      // Streaming from empty: count settles at 1.
      bv = 1; bm = 1;
      for (int i = 0; i < 20; i++) begin
         bd = DW'(10'h100 + i);
         cycle();
      end
      check("stream_count", 32'(b_count), 32'(1));
      drain();

      // Drop mode overflow.
      for (int i = 0; i < 6; i++) begin
         dv = 1; dd = DW'(10'h010 + i);
         cycle();
      end
      dv = 0;
      cycle();
      drain();

      // Randomized traffic on both instances.
      pushed = 0;
      budget = 20000;
      bd = '0;
      while (pushed < 1000 && budget > 0) begin
         bv = ($urandom_range(0, 3) != 0);
         bm = ($urandom_range(0, 9) < 6);
         dv = ($urandom_range(0, 1) != 0);
         dm = ($urandom_range(0, 2) != 0);
         dd = DW'($urandom);
         cycle();
         if (last_wr_b) begin
            pushed++;
            bd = bd + DW'(1);
         end
         budget--;
      end
      check("rand_beats", 32'(pushed >= 1000), 32'(1));
      drain();

      // Mid-stream reset with a beat presented during reset.
      bv = 1; dv = 1;
      for (int i = 0; i < 3; i++) begin
         bd = DW'(10'h020 + i); dd = DW'(10'h030 + i);
         cycle();
      end
      bd = 10'h3ff; dd = 10'h3ff;
      rst = 1;
      cycle();
      rst = 0; bv = 0; dv = 0;
      cycle();
      check("post_rst_count", 32'(b_count), 32'(0));
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
